// File: rtl/skin_decision.sv
// Skin-mask decision stage: thresholds sigmoid outputs to raw skin bits, majority-filters them over a
// per-line sliding window, and reports a running per-line skin count through a single-entry output register.
module skin_decision #(
   parameter logic [7:0] THRESH = 8'd128,
   parameter int         WIN    = 5,
   parameter int         LINE_W = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_skin,
   output logic              out_raw,
   output logic              out_last,
   output logic [LINE_W-1:0] out_idx,
   output logic [LINE_W-1:0] out_linecnt,
   output logic              o_dbg_state
);

   // Handshake: a beat moves on an edge where valid && ready are both high; a held output
   // (out_valid && !out_ready) keeps every out_* field stable until it is taken.
   typedef enum logic {IDLE = 1'b0, LINE = 1'b1} state_t;

   localparam logic [LINE_W-1:0] CNT_MAX = '1;
   localparam logic [3:0]        HALF    = 4'(WIN / 2);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [WIN-1:0]      r_win;
   logic [3:0]          r_wcnt;
   logic [LINE_W-1:0]   r_idx;
   logic [LINE_W-1:0]   r_linecnt;
   logic                r_out_valid;
   logic                r_out_skin;
   logic                r_out_raw;
   logic                r_out_last;
   logic [LINE_W-1:0]   r_out_idx;
   logic [LINE_W-1:0]   r_out_linecnt;

   logic                w_accept;
   logic                w_raw;
   logic [WIN-1:0]      w_win_new;
   logic [3:0]          w_wcnt_new;
   logic                w_skin;
   logic [LINE_W-1:0]   w_idx_inc;
   logic [LINE_W-1:0]   w_lc_new;

   assign in_ready   = !r_out_valid || out_ready;
   assign w_accept   = in_valid && in_ready;
   assign w_raw      = (in_data >= THRESH);
   assign w_win_new  = {r_win[WIN-2:0], w_raw};
   assign w_wcnt_new = r_wcnt + 4'(w_raw) - 4'(r_win[WIN-1]);
   assign w_skin     = (w_wcnt_new > HALF);
   assign w_idx_inc  = (r_idx == CNT_MAX) ? r_idx : r_idx + 1'b1;
   assign w_lc_new   = (w_skin && (r_linecnt != CNT_MAX)) ? r_linecnt + 1'b1 : r_linecnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (clear)         w_state_nxt = IDLE;
      else if (w_accept) w_state_nxt = in_last ? IDLE : LINE;
   end

   // Window and counters restart at every line end so the next line sees implicit zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_win         <= '0;
         r_wcnt        <= '0;
         r_idx         <= '0;
         r_linecnt     <= '0;
         r_out_valid   <= 1'b0;
         r_out_skin    <= 1'b0;
         r_out_raw     <= 1'b0;
         r_out_last    <= 1'b0;
         r_out_idx     <= '0;
         r_out_linecnt <= '0;
      end else if (clear) begin
         r_win         <= '0;
         r_wcnt        <= '0;
         r_idx         <= '0;
         r_linecnt     <= '0;
         r_out_valid   <= 1'b0;
      end else if (w_accept) begin
         r_out_valid   <= 1'b1;
         r_out_skin    <= w_skin;
         r_out_raw     <= w_raw;
         r_out_last    <= in_last;
         r_out_idx     <= r_idx;
         r_out_linecnt <= w_lc_new;
         if (in_last) begin
            r_win     <= '0;
            r_wcnt    <= '0;
            r_idx     <= '0;
            r_linecnt <= '0;
         end else begin
            r_win     <= w_win_new;
            r_wcnt    <= w_wcnt_new;
            r_idx     <= w_idx_inc;
            r_linecnt <= w_lc_new;
         end
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid   = r_out_valid;
   assign out_skin    = r_out_skin;
   assign out_raw     = r_out_raw;
   assign out_last    = r_out_last;
   assign out_idx     = r_out_idx;
   assign out_linecnt = r_out_linecnt;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_skin_decision.sv
// Directed bench for skin_decision: a behavioural model pushes expected outputs on every accepted
// pixel, and a monitor pops and compares them whenever an output beat transfers.
module tb_skin_decision;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic        out_skin;
   logic        out_raw;
   logic        out_last;
   logic [10:0] out_idx;
   logic [10:0] out_linecnt;
   logic        dbg_state;

   logic        ready_cmd;
   logic        rand_en;
   logic        rnd_bit;

   int          n_assert = 0;
   int          n_fail   = 0;

   // {raw, skin, last, idx[10:0], linecnt[10:0]}
   logic [24:0] exp_q[$];
   bit          hist[$];
   int          m_idx;
   int          m_lc;
   logic [10:0] last_idx;
   logic [10:0] last_lc;
   int          stalls;

   always #5 clk = ~clk;

   assign out_ready = rand_en ? rnd_bit : ready_cmd;

   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end

   skin_decision dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_skin    (out_skin),
      .out_raw     (out_raw),
      .out_last    (out_last),
      .out_idx     (out_idx),
      .out_linecnt (out_linecnt),
      .o_dbg_state (dbg_state)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function void model_reset();
      hist.delete();
      m_idx = 0;
      m_lc  = 0;
   endfunction

   // Reference: count the raw bits of the last five accepted pixels of the current line.
   function void model_push(input logic [7:0] d, input logic l);
      int  cnt;
      bit  raw;
      bit  skin;
      raw = (d >= 8'd128);
      hist.push_back(raw);
      if (hist.size() > 5) void'(hist.pop_front());
      cnt = 0;
      foreach (hist[k]) if (hist[k]) cnt++;
      skin = (cnt >= 3);
      if (skin && m_lc < 2047) m_lc++;
      exp_q.push_back({raw, skin, l, 11'(m_idx), 11'(m_lc)});
      if (l) model_reset();
      else if (m_idx < 2047) m_idx++;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         check("exp_available", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            check("out_fields", 32'({out_raw, out_skin, out_last, out_idx, out_linecnt}),
                  32'(exp_q.pop_front()));
            last_idx = out_idx;
            last_lc  = out_linecnt;
         end
      end
   end

   task automatic send_pixel(input logic [7:0] d, input logic l, output int st);
      logic acc;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      acc      = 1'b0;
      st       = 0;
      while (!acc && st < 50) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (!acc) st++;
      end
      in_valid = 1'b0;
      check("accepted", 32'(acc), 32'd1);
      if (acc) model_push(d, l);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] t1 [4];
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      ready_cmd = 1'b1; rand_en = 1'b0;
      model_reset();
      #12;
      check("rst_outputs", 32'({out_valid, out_skin, out_raw, out_last, out_idx, out_linecnt}), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Threshold edge, single-pixel lines
      t1[0] = 8'd127; t1[1] = 8'd128; t1[2] = 8'd255; t1[3] = 8'd0;
      for (int i = 0; i < 4; i++) send_pixel(t1[i], 1'b1, stalls);
      drain();

      // Majority over one line
      for (int i = 0; i < 8; i++) send_pixel((i < 5) ? 8'd200 : 8'd10, (i == 7), stalls);
      drain();
      check("t2_linecnt", 32'(last_lc), 32'd5);
      check("t2_idx", 32'(last_idx), 32'd7);

      // Line boundary
      send_pixel(8'd0, 1'b0, stalls);
      for (int i = 0; i < 5; i++) send_pixel(8'd200, (i == 4), stalls);
      send_pixel(8'd200, 1'b0, stalls);
      send_pixel(8'd200, 1'b0, stalls);
      send_pixel(8'd0, 1'b0, stalls);
      send_pixel(8'd200, 1'b1, stalls);
      drain();

      // Backpressure then full rate
      ready_cmd = 1'b0;
      send_pixel(8'd200, 1'b0, stalls);
      in_valid = 1'b1; in_data = 8'd210; in_last = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_hold", 32'({out_raw, out_skin, out_last, out_idx, out_linecnt}), 32'(exp_q[0]));
         @(posedge clk);
         #1;
      end
      ready_cmd = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send_pixel((i % 3 == 2) ? 8'd5 : 8'd210, (i == 6), stalls);
         check("full_rate", 32'(stalls), 32'd0);
      end
      drain();

      // Synchronous clear mid-line
      for (int i = 0; i < 3; i++) send_pixel(8'd220, 1'b0, stalls);
      in_valid = 1'b1; in_data = 8'd255; in_last = 1'b0; clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0; in_valid = 1'b0;
      model_reset();
      @(negedge clk);
      check("clear_out_valid", 32'(out_valid), 32'd0);
      check("clear_state", 32'(dbg_state), 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) send_pixel(8'd230, (i == 3), stalls);
      drain();

      // Asynchronous reset mid-line
      for (int i = 0; i < 3; i++) send_pixel(8'd240, 1'b0, stalls);
      check("state_line", 32'(dbg_state), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_outputs", 32'({out_valid, out_skin, out_raw, out_last, out_idx, out_linecnt}), 32'd0);
      check("arst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 6; i++) send_pixel(8'd150, (i == 5), stalls);
      drain();

      // Random data, random line ends, random output stalls
      rand_en = 1'b1;
      for (int i = 0; i < 60; i++)
         send_pixel(8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0) || (i == 59), stalls);
      rand_en = 1'b0;
      drain();

      // Long line to exercise index and count saturation
      for (int i = 0; i < 2052; i++) send_pixel((i % 8 == 7) ? 8'd0 : 8'd255, (i == 2051), stalls);
      drain();
      check("sat_idx", 32'(last_idx), 32'd2047);
      check("sat_linecnt", 32'(last_lc), 32'd2047);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
